// File: rtl/gvizi_regs_pkg.sv
// Shared register-map constants, frame layout and decode types for the SPI command decoder.
package gvizi_regs_pkg;

    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned CH_IDX_W = 4;
    localparam int unsigned FIELD_W  = 16;

    localparam int unsigned RW_BIT   = 23;
    localparam int unsigned ADDR_MSB = 22;
    localparam int unsigned ADDR_LSB = 16;

    localparam logic [ADDR_W-1:0] ADDR_CTRL       = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_ARM        = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_STATUS     = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_ID         = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DELAY_BASE = 7'h10;
    localparam logic [ADDR_W-1:0] ADDR_WIDTH_BASE = 7'h20;

    localparam logic [23:0] ERR_RESP = 24'hFF_DEAD;

    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC} state_e;

    typedef enum logic [1:0] {ACC_RW, ACC_RO, ACC_WO, ACC_INVALID} acc_e;

    typedef enum logic [2:0] {TGT_CTRL, TGT_ARM, TGT_STATUS, TGT_ID, TGT_DELAY, TGT_WIDTH} tgt_e;

    typedef struct packed {
        acc_e acc;
        tgt_e tgt;
    } dec_t;

    // Map an address to its target register and the directions it permits.
    function automatic dec_t classify(input logic [ADDR_W-1:0] addr, input int unsigned num_ch);
        dec_t r;
        logic ch_ok;
        r.acc = ACC_INVALID;
        r.tgt = TGT_CTRL;
        ch_ok = 32'(addr[CH_IDX_W-1:0]) < num_ch;
        if (addr == ADDR_CTRL) begin
            r.acc = ACC_RW;
        end else if (addr == ADDR_ARM) begin
            r.acc = ACC_WO;
            r.tgt = TGT_ARM;
        end else if (addr == ADDR_STATUS) begin
            r.acc = ACC_RW;
            r.tgt = TGT_STATUS;
        end else if (addr == ADDR_ID) begin
            r.acc = ACC_RO;
            r.tgt = TGT_ID;
        end else if (addr[ADDR_W-1:CH_IDX_W] == ADDR_DELAY_BASE[ADDR_W-1:CH_IDX_W]) begin
            r.acc = ch_ok ? ACC_RW : ACC_INVALID;
            r.tgt = TGT_DELAY;
        end else if (addr[ADDR_W-1:CH_IDX_W] == ADDR_WIDTH_BASE[ADDR_W-1:CH_IDX_W]) begin
            r.acc = ch_ok ? ACC_RW : ACC_INVALID;
            r.tgt = TGT_WIDTH;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_bank.sv
// Per-channel shadow/active delay and width registers; commit copies every shadow to active at once.
module ch_shadow_bank
    import gvizi_regs_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned REG_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic                     sel_width_i,
    input  logic [CH_IDX_W-1:0]      ch_i,
    input  logic [REG_W-1:0]         wr_data_i,
    input  logic                     commit_i,
    output logic [REG_W-1:0]         rd_data_o,
    output logic [NUM_CH*REG_W-1:0]  delay_o,
    output logic [NUM_CH*REG_W-1:0]  width_o
);

    logic [REG_W-1:0] shd_dly_q [NUM_CH];
    logic [REG_W-1:0] shd_wid_q [NUM_CH];
    logic [REG_W-1:0] act_dly_q [NUM_CH];
    logic [REG_W-1:0] act_wid_q [NUM_CH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                shd_dly_q[i] <= '0;
                shd_wid_q[i] <= '0;
                act_dly_q[i] <= '0;
                act_wid_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (wr_en_i && ch_i == CH_IDX_W'(i)) begin
                    if (sel_width_i) shd_wid_q[i] <= wr_data_i;
                    else             shd_dly_q[i] <= wr_data_i;
                end
                if (commit_i) begin
                    act_dly_q[i] <= shd_dly_q[i];
                    act_wid_q[i] <= shd_wid_q[i];
                end
            end
        end
    end

    // Read-back always reflects the shadow copy.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (ch_i == CH_IDX_W'(i)) rd_data_o = sel_width_i ? shd_wid_q[i] : shd_dly_q[i];
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_out
        assign delay_o[g*REG_W +: REG_W] = act_dly_q[g];
        assign width_o[g*REG_W +: REG_W] = act_wid_q[g];
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI words into register-map accesses, drives the channel registers and builds the response word.
module spi_cmd_decoder
    import gvizi_regs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned REG_W      = 16,
    parameter logic [15:0] ID_VALUE   = 16'hD123
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    output logic [DATA_WIDTH-1:0]    tx_data,
    input  logic                     gen_busy,
    output logic [NUM_CH-1:0]        ch_enable,
    output logic [NUM_CH*REG_W-1:0]  ch_delay,
    output logic [NUM_CH*REG_W-1:0]  ch_width,
    output logic                     arm_pulse,
    output logic [1:0]               err
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   frame_q, frame_d;
    dec_t                    dec_q, dec_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [NUM_CH-1:0]       en_q, en_d;
    logic                    arm_q, arm_d;
    logic [1:0]              err_q, err_d;

    logic [ADDR_W-1:0]       addr;
    logic                    is_rd;
    logic [FIELD_W-1:0]      wdata;
    logic                    bad;
    logic [FIELD_W-1:0]      rdata;
    logic [1:0]              err_set, err_clr;
    logic                    bank_wr_en, bank_commit;
    logic [REG_W-1:0]        bank_rd_data;

    assign addr  = frame_q[ADDR_MSB:ADDR_LSB];
    assign is_rd = frame_q[RW_BIT];
    assign wdata = frame_q[FIELD_W-1:0];

    ch_shadow_bank #(.NUM_CH(NUM_CH), .REG_W(REG_W)) u_bank (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (bank_wr_en),
        .sel_width_i (dec_q.tgt == TGT_WIDTH),
        .ch_i        (addr[CH_IDX_W-1:0]),
        .wr_data_i   (REG_W'(wdata)),
        .commit_i    (bank_commit),
        .rd_data_o   (bank_rd_data),
        .delay_o     (ch_delay),
        .width_o     (ch_width)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            dec_q   <= '0;
            tx_q    <= '0;
            en_q    <= '0;
            arm_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            dec_q   <= dec_d;
            tx_q    <= tx_d;
            en_q    <= en_d;
            arm_q   <= arm_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        dec_d       = dec_q;
        tx_d        = tx_q;
        en_d        = en_q;
        arm_d       = 1'b0;
        err_set     = '0;
        err_clr     = '0;
        bad         = 1'b0;
        rdata       = '0;
        bank_wr_en  = 1'b0;
        bank_commit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    frame_d = rx_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                dec_d   = classify(addr, NUM_CH);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                bad = (dec_q.acc == ACC_INVALID) ||
                      (dec_q.acc == ACC_RO && !is_rd) ||
                      (dec_q.acc == ACC_WO && is_rd);
                if (bad) begin
                    tx_d       = ERR_RESP;
                    err_set[0] = 1'b1;
                end else if (is_rd) begin
                    case (dec_q.tgt)
                        TGT_CTRL:   rdata = FIELD_W'(en_q);
                        TGT_STATUS: rdata = {13'b0, gen_busy, err_q};
                        TGT_ID:     rdata = ID_VALUE;
                        TGT_DELAY,
                        TGT_WIDTH:  rdata = FIELD_W'(bank_rd_data);
                        default:    rdata = '0;
                    endcase
                    tx_d = {frame_q[DATA_WIDTH-1:FIELD_W], rdata};
                end else begin
                    tx_d = {frame_q[DATA_WIDTH-1:FIELD_W], wdata};
                    case (dec_q.tgt)
                        TGT_CTRL:   en_d = wdata[NUM_CH-1:0];
                        TGT_ARM: begin
                            if (wdata[0]) begin
                                if (gen_busy) begin
                                    err_set[1] = 1'b1;
                                end else begin
                                    arm_d       = 1'b1;
                                    bank_commit = 1'b1;
                                end
                            end
                        end
                        TGT_STATUS: err_clr = wdata[1:0];
                        TGT_DELAY,
                        TGT_WIDTH:  bank_wr_en = 1'b1;
                        default:    ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A word arriving mid-command is dropped; setting beats a same-cycle clear.
        if (rx_valid && state_q != ST_IDLE) err_set[1] = 1'b1;
        err_d = (err_q & ~err_clr) | err_set;
    end

    assign tx_data   = tx_q;
    assign ch_enable = en_q;
    assign arm_pulse = arm_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: directed map checks plus randomized traffic against a register-map model.
module tb_spi_cmd_decoder;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned REG_W  = 16;
    localparam int unsigned DW     = 24;
    localparam int unsigned FLAT_W = NUM_CH * REG_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [DW-1:0]     rx_data = '0;
    logic              gen_busy = 1'b0;
    logic [DW-1:0]     tx_data;
    logic [NUM_CH-1:0] ch_enable;
    logic [FLAT_W-1:0] ch_delay;
    logic [FLAT_W-1:0] ch_width;
    logic              arm_pulse;
    logic [1:0]        err;

    always #5 clk = ~clk;

    spi_cmd_decoder #(.DATA_WIDTH(DW), .NUM_CH(NUM_CH), .REG_W(REG_W), .ID_VALUE(16'hD123)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_data   (tx_data),
        .gen_busy  (gen_busy),
        .ch_enable (ch_enable),
        .ch_delay  (ch_delay),
        .ch_width  (ch_width),
        .arm_pulse (arm_pulse),
        .err       (err)
    );

    typedef struct {
        int                due;
        logic [DW-1:0]     tx;
        logic [NUM_CH-1:0] en;
        logic [FLAT_W-1:0] dly;
        logic [FLAT_W-1:0] wid;
        logic [1:0]        err;
        logic              arm;
    } exp_t;

    exp_t sbq[$];
    int   cyc  = 0;
    int   nchk = 0;
    int   nerr = 0;
    logic mon_arm;

    // Behavioural register map.
    logic [NUM_CH-1:0] m_en;
    logic [15:0]       m_sdly [NUM_CH];
    logic [15:0]       m_swid [NUM_CH];
    logic [15:0]       m_adly [NUM_CH];
    logic [15:0]       m_awid [NUM_CH];
    logic [1:0]        m_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_en  = '0;
        m_err = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_sdly[i] = '0; m_swid[i] = '0; m_adly[i] = '0; m_awid[i] = '0;
        end
    endtask

    task automatic model_cmd(input logic [23:0] w, input logic busy, output logic [23:0] tx, output logic arm);
        int          a, grp, ch;
        logic        rd, bad;
        logic [15:0] d, rdat;
        a    = int'(w[22:16]);
        grp  = a / 16;
        ch   = a % 16;
        rd   = w[23];
        d    = w[15:0];
        bad  = 1'b0;
        rdat = '0;
        arm  = 1'b0;
        if (a == 0) begin
            if (rd) rdat = 16'(m_en);
            else    m_en = d[NUM_CH-1:0];
        end else if (a == 1) begin
            if (rd) bad = 1'b1;
            else if (d[0]) begin
                if (busy) m_err[1] = 1'b1;
                else begin
                    arm = 1'b1;
                    for (int i = 0; i < int'(NUM_CH); i++) begin
                        m_adly[i] = m_sdly[i];
                        m_awid[i] = m_swid[i];
                    end
                end
            end
        end else if (a == 2) begin
            if (rd) rdat = {13'b0, busy, m_err};
            else    m_err = m_err & ~d[1:0];
        end else if (a == 3) begin
            if (rd) rdat = 16'hD123;
            else    bad = 1'b1;
        end else if ((grp == 1 || grp == 2) && ch < int'(NUM_CH)) begin
            if (grp == 1) begin
                if (rd) rdat = m_sdly[ch]; else m_sdly[ch] = d;
            end else begin
                if (rd) rdat = m_swid[ch]; else m_swid[ch] = d;
            end
        end else begin
            bad = 1'b1;
        end
        if (bad) begin
            m_err[0] = 1'b1;
            tx = 24'hFFDEAD;
        end else begin
            tx = {w[23:16], rd ? rdat : d};
        end
    endtask

    task automatic push_exp(input int due, input logic [23:0] tx, input logic arm);
        exp_t e;
        e.due = due;
        e.tx  = tx;
        e.en  = m_en;
        e.err = m_err;
        e.arm = arm;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            e.dly[i*16 +: 16] = m_adly[i];
            e.wid[i*16 +: 16] = m_awid[i];
        end
        sbq.push_back(e);
    endtask

    // Issue one word; ovr=1/2 injects a stray word in the DECODE/EXEC cycle. Returns in the response cycle.
    task automatic send(input logic [23:0] w, input logic busy, input int ovr);
        logic [23:0] tx;
        logic        arm;
        int          k;
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = w;
        gen_busy = busy;
        k = cyc;
        if (ovr == 1) m_err[1] = 1'b1;
        model_cmd(w, busy, tx, arm);
        if (ovr == 2) m_err[1] = 1'b1;
        push_exp(k + 3, tx, arm);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            rx_valid = (c == ovr);
            if (c == ovr) rx_data = 24'($urandom);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx"},  64'(tx_data),   64'h0);
        chk({tag, "_en"},  64'(ch_enable), 64'h0);
        chk({tag, "_dly"}, ch_delay,       64'h0);
        chk({tag, "_wid"}, ch_width,       64'h0);
        chk({tag, "_arm"}, 64'(arm_pulse), 64'h0);
        chk({tag, "_err"}, 64'(err),       64'h0);
    endtask

    // Monitor: compare the due response, and require arm_pulse low on every other cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            mon_arm = 1'b0;
            while (sbq.size() != 0 && sbq[0].due < cyc) begin
                chk("sb_missed", 64'(sbq[0].due), 64'(cyc));
                void'(sbq.pop_front());
            end
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("sb_tx",  64'(tx_data),   64'(e.tx));
                chk("sb_en",  64'(ch_enable), 64'(e.en));
                chk("sb_dly", ch_delay,       e.dly);
                chk("sb_wid", ch_width,       e.wid);
                chk("sb_err", 64'(err),       64'(e.err));
                mon_arm = e.arm;
            end
            chk("arm_pulse", 64'(arm_pulse), 64'(mon_arm));
        end
    end

    initial begin
        logic [6:0]  a;
        logic [15:0] d;
        int          sel, ovr;

        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_all_zero("reset");

        send(24'h830000, 1'b0, 0);
        chk("id_read", 64'(tx_data), 64'h83D123);

        send(24'h110400, 1'b0, 0);
        chk("dly1_before_arm", 64'(ch_delay[31:16]), 64'h0);
        send(24'h910000, 1'b0, 0);
        chk("dly1_shadow_read", 64'(tx_data), 64'h910400);
        send(24'h010001, 1'b0, 0);
        chk("arm_pulse_hi", 64'(arm_pulse), 64'h1);
        chk("dly1_after_arm", 64'(ch_delay[31:16]), 64'h0400);

        send(24'h110777, 1'b0, 0);
        send(24'h010001, 1'b1, 0);
        chk("arm_busy_err", 64'(err), 64'h2);
        chk("arm_busy_dly", 64'(ch_delay[31:16]), 64'h0400);
        send(24'h020002, 1'b0, 0);
        chk("status_clear", 64'(err), 64'h0);

        send(24'h140055, 1'b0, 0);
        chk("bad_ch_tx", 64'(tx_data), 64'hFFDEAD);
        chk("bad_ch_err", 64'(err), 64'h1);
        send(24'h810000, 1'b0, 0);
        chk("arm_read_tx", 64'(tx_data), 64'hFFDEAD);
        send(24'h020001, 1'b0, 0);

        send(24'h000003, 1'b0, 1);
        chk("overrun_err", 64'(err), 64'h2);
        chk("overrun_en", 64'(ch_enable), 64'h3);
        send(24'h020002, 1'b0, 0);

        // Reset lands in the DECODE cycle of a width write.
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = 24'h20ABCD;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk_all_zero("mid_reset");
        send(24'hA00000, 1'b0, 0);
        chk("mid_reset_wid_rd", 64'(tx_data), 64'hA00000);

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3: a = 7'(sel);
                4, 5:       a = 7'(16 + int'($urandom_range(0, 5)));
                6, 7:       a = 7'(32 + int'($urandom_range(0, 5)));
                8:          a = 7'($urandom);
                default:    a = 7'd1;
            endcase
            d = 16'($urandom);
            if (a == 7'd1 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            case ($urandom_range(0, 9))
                0:       ovr = 1;
                1:       ovr = 2;
                default: ovr = 0;
            endcase
            send({1'($urandom), a, d}, ($urandom_range(0, 3) == 0), ovr);
        end

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain", 64'(sbq.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
